cc_line_serializer: RTL and testbench

//  Converts one buffered cache-hit line (512b data + 6b byte offset) into an AXI-style
//  R-channel burst of 8 x 64b beats, critical word first, wrapping within the line.

---
 rtl/cc_line_serializer.sv | 108 ++++++++++
 tb/tb_cc_line_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_serializer.sv
// Cache-hit line serializer: pops one {line, offset} entry from a show-ahead FIFO and
// emits it as a fixed 8-beat burst, critical word first, wrapping within the line.
module cc_line_serializer #(
  parameter int LINE_WIDTH   = 512,
  parameter int OFFSET_WIDTH = 6,
  parameter int BEAT_WIDTH   = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty_i,
  input  logic                             fifo_aempty_i,
  input  logic [LINE_WIDTH+OFFSET_WIDTH-1:0] fifo_rdata_i,
  output logic                             fifo_rden_o,
  output logic [BEAT_WIDTH-1:0]            rdata_o,
  output logic                             rlast_o,
  output logic                             rvalid_o,
  input  logic                             rready_i
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int IDX_W = $clog2(BEATS);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [IDX_W-1:0]        start_q;
  logic [IDX_W-1:0]        beat_q, beat_d;
  logic [IDX_W-1:0]        idx;
  logic                    load;
  logic                    handshake;
  logic                    last_beat;

  // Almost-empty and the sub-word byte offset carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{fifo_aempty_i, fifo_rdata_i[OFFSET_WIDTH-IDX_W-1:0]};

  assign rvalid_o  = (state_q == SEND);
  assign handshake = rvalid_o && rready_i;
  assign last_beat = (beat_q == IDX_W'(BEATS - 1));
  assign rlast_o   = rvalid_o && last_beat;

  // Word index wraps naturally in IDX_W bits, giving critical-word-first order.
  assign idx     = start_q + beat_q;
  assign rdata_o = line_q[idx*BEAT_WIDTH +: BEAT_WIDTH];

  // NOTE: every output of an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    load        = 1'b0;
    fifo_rden_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          fifo_rden_o = 1'b1;
          load        = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            if (!fifo_empty_i) begin
              // Chain straight into the next line with no idle cycle.
              fifo_rden_o = 1'b1;
              load        = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) beat_d = '0;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: the wide line register is reset too, so rdata_o reads zero out of reset
  // instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= '0;
      start_q <= '0;
    end else if (load) begin
      line_q  <= fifo_rdata_i[LINE_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
      start_q <= fifo_rdata_i[OFFSET_WIDTH-1:OFFSET_WIDTH-IDX_W];
    end
  end

endmodule

// File: tb/tb_cc_line_serializer.sv
// Self-checking bench for cc_line_serializer: bench-owned FIFO queue, beat-stream
// scoreboard model, directed scenarios plus a randomized traffic phase.
module tb_cc_line_serializer;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty_i;
  logic         fifo_aempty_i;
  logic [517:0] fifo_rdata_i;
  logic         fifo_rden_o;
  logic [63:0]  rdata_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rready_i;

  cc_line_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_aempty_i(fifo_aempty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .rdata_o      (rdata_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic [517:0] fifo_q[$];
  beat_t        exp_q[$];

  int          n_checks;
  int          n_fails;
  int          hs_cnt;
  int          rden_cnt;
  int          valid_cnt;
  logic [63:0] first_hs_data;
  logic [63:0] last_hs_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] pattern_line();
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = (64'h1111_0000_0000_0000 * i) | 64'(i);
    return l;
  endfunction

  function automatic logic [511:0] random_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_rdata_i = fifo_empty_i ? '0 : fifo_q[0];
  endtask

  task automatic push_entry(input logic [511:0] line, input logic [5:0] offset);
    fifo_q.push_back({line, offset});
    drive_fifo();
  endtask

  // One clock: compare DUT against the model at negedge, then advance the model.
  task automatic cycle();
    logic         exp_rden;
    logic         exp_valid;
    logic         hs;
    logic [517:0] e;
    logic [511:0] l;
    int           start;
    beat_t        b;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_rden  = !fifo_empty_i && (!exp_valid || (exp_q.size() == 1 && rready_i));
    check("rvalid", 64'(rvalid_o), 64'(exp_valid));
    check("fifo_rden", 64'(fifo_rden_o), 64'(exp_rden));
    if (exp_valid) begin
      check("rdata", rdata_o, exp_q[0].data);
      check("rlast", 64'(rlast_o), 64'(exp_q[0].last));
    end
    if (rvalid_o) valid_cnt++;
    hs = exp_valid && rready_i;
    if (hs) begin
      if (hs_cnt == 0) first_hs_data = rdata_o;
      last_hs_data = rdata_o;
      hs_cnt++;
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (exp_rden) begin
      e     = fifo_q.pop_front();
      l     = e[517:6];
      start = int'(e[5:3]);
      for (int k = 0; k < 8; k++) begin
        b.data = l[64*((start + k) % 8) +: 64];
        b.last = (k == 7);
        exp_q.push_back(b);
      end
      rden_cnt++;
    end
    drive_fifo();
  endtask

  task automatic reset_counts();
    hs_cnt    = 0;
    rden_cnt  = 0;
    valid_cnt = 0;
  endtask

  // Run until the model has drained or the cycle budget runs out.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_drain_timeout"}, 64'(exp_q.size() + fifo_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_fails       = 0;
    first_hs_data = '0;
    last_hs_data  = '0;
    reset_counts();
    rst_n         = 1'b0;
    fifo_aempty_i = 1'b0;
    rready_i      = 1'b0;
    drive_fifo();
    #1;
    check("reset_rvalid", 64'(rvalid_o), 64'd0);
    check("reset_rlast", 64'(rlast_o), 64'd0);
    check("reset_rdata", rdata_o, 64'd0);
    check("reset_rden", 64'(fifo_rden_o), 64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Aligned line, words 0..7, one pop.
    reset_counts();
    rready_i = 1'b1;
    push_entry(pattern_line(), 6'h00);
    drain("aligned", 40);
    repeat (2) cycle();
    check("aligned_first", first_hs_data, 64'h0);
    check("aligned_last", last_hs_data, 64'h7777_0000_0000_0007);
    check("aligned_beats", 64'(hs_cnt), 64'd8);
    check("aligned_pops", 64'(rden_cnt), 64'd1);

    // Wrap from word 5, low offset bits set to show they are ignored.
    reset_counts();
    push_entry(pattern_line(), 6'h2f);
    drain("wrap", 40);
    repeat (2) cycle();
    check("wrap_first", first_hs_data, 64'h5555_0000_0000_0005);
    check("wrap_last", last_hs_data, 64'h4444_0000_0000_0004);
    check("wrap_beats", 64'(hs_cnt), 64'd8);

    // Back-pressure with random ready; stability is checked every stalled cycle.
    reset_counts();
    push_entry(pattern_line(), 6'h38);
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 200) begin
      rready_i = $urandom_range(1, 0) != 0;
      cycle();
      n++;
    end
    check("bp_drain_timeout", 64'(exp_q.size() + fifo_q.size()), 64'd0);
    rready_i = 1'b1;
    repeat (2) cycle();
    check("bp_first", first_hs_data, 64'h7777_0000_0000_0007);
    check("bp_last", last_hs_data, 64'h6666_0000_0000_0006);
    check("bp_beats", 64'(hs_cnt), 64'd8);

    // Back-to-back: three preloaded entries, 24 beats with no bubble.
    reset_counts();
    push_entry(random_line(), 6'(8 * $urandom_range(7, 0)));
    push_entry(random_line(), 6'(8 * $urandom_range(7, 0)));
    push_entry(random_line(), 6'(8 * $urandom_range(7, 0)));
    repeat (25) cycle();
    check("b2b_valid_cycles", 64'(valid_cnt), 64'd24);
    check("b2b_pops", 64'(rden_cnt), 64'd3);
    check("b2b_beats", 64'(hs_cnt), 64'd24);
    repeat (2) cycle();

    // Empty guard: long idle, then one entry; valid rises one cycle after empty falls.
    reset_counts();
    repeat (20) cycle();
    check("guard_idle_pops", 64'(rden_cnt), 64'd0);
    push_entry(random_line(), 6'h10);
    cycle();
    check("guard_pop", 64'(rden_cnt), 64'd1);
    check("guard_valid_early", 64'(valid_cnt), 64'd0);
    cycle();
    check("guard_valid_rise", 64'(valid_cnt), 64'd1);
    drain("guard", 40);

    // Reset mid-burst at beat 3: outputs clear at once, entry is not replayed.
    reset_counts();
    push_entry(pattern_line(), 6'h00);
    n = 0;
    while (hs_cnt < 3 && n < 40) begin
      cycle();
      n++;
    end
    check("rst_reach_beat3", 64'(hs_cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_mid_rlast", 64'(rlast_o), 64'd0);
    check("rst_mid_rdata", rdata_o, 64'd0);
    check("rst_mid_rden", 64'(fifo_rden_o), 64'd0);
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (5) cycle();

    // Randomized traffic: random arrivals, offsets, data and ready.
    reset_counts();
    for (int c = 0; c < 600; c++) begin
      if (fifo_q.size() < 3 && $urandom_range(5, 0) == 0)
        push_entry(random_line(), 6'($urandom_range(63, 0)));
      rready_i = $urandom_range(3, 0) != 0;
      cycle();
    end
    rready_i = 1'b1;
    drain("random", 200);
    check("random_beats_per_pop", 64'(hs_cnt), 64'(8 * rden_cnt));
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
